// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: opcodes, instruction field
// positions, default sizes and opcode classification helpers.
package decode_issue_pkg;

  localparam int DEF_NREGS        = 8;
  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int DEF_DW           = 10;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;
  localparam int RA_W    = 3;
  localparam int IMM_W   = 9;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h5;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic op_reads(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return op_reads(op) || (op == OP_LDI);
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op_writes(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Instruction, register-file read, issue and writeback signals of the
// decode/issue stage; the stage itself uses the slave view.
interface decode_issue_if
  import decode_issue_pkg::*;
#(
  parameter int DW = DEF_DW
) ();

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [RA_W-1:0]    rs1;
  logic [RA_W-1:0]    rs2;
  logic               rf;
  logic               ex_valid;
  logic [OP_W-1:0]    ex_op;
  logic [RA_W-1:0]    ex_ws;
  logic [DW-1:0]      ex_imm;
  logic               wb_valid;
  logic [RA_W-1:0]    wb_ws;
  logic               halted;
  logic               illegal;

  modport master (
    output instr_valid, instr, wb_valid, wb_ws,
    input  instr_ready, rs1, rs2, rf, ex_valid, ex_op, ex_ws, ex_imm,
           halted, illegal
  );

  modport slave (
    input  instr_valid, instr, wb_valid, wb_ws,
    output instr_ready, rs1, rs2, rf, ex_valid, ex_op, ex_ws, ex_imm,
           halted, illegal
  );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// Per-register busy bits: set on issue of a write, cleared on writeback;
// a set and a clear of the same register on one edge leaves it busy.
module decode_issue_scoreboard
  import decode_issue_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en_i,
  input  logic [RA_W-1:0] set_idx_i,
  input  logic            clr_en_i,
  input  logic [RA_W-1:0] clr_idx_i,
  input  logic [RA_W-1:0] rs1_i,
  input  logic [RA_W-1:0] rs2_i,
  input  logic [RA_W-1:0] rd_i,
  output logic            busy_rs1_o,
  output logic            busy_rs2_o,
  output logic            busy_rd_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  // Decode set/clear one-hot masks; the set is applied last so it wins.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      set_mask_s[i] = set_en_i && (set_idx_i == RA_W'(i));
      clr_mask_s[i] = clr_en_i && (clr_idx_i == RA_W'(i));
    end
    busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
  end

  // Busy-bit register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1_o = busy_q[rs1_i];
  assign busy_rs2_o = busy_q[rs2_i];
  assign busy_rd_o  = busy_q[rd_i];

endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: decodes 16-bit instructions, stalls on scoreboard
// hazards or a full in-flight window, and registers regfile/issue controls.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int NREGS        = DEF_NREGS,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int DW           = DEF_DW
) (
  input logic           clk,
  input logic           rst_n,
  decode_issue_if.slave bus
);

  localparam int              CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_INFLIGHT);

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    inflight_d;

  logic [RA_W-1:0]  rs1_q;
  logic [RA_W-1:0]  rs2_q;
  logic             rf_q;
  logic             ex_valid_q;
  logic [OP_W-1:0]  ex_op_q;
  logic [RA_W-1:0]  ex_ws_q;
  logic [DW-1:0]    ex_imm_q;
  logic             illegal_q;

  logic [OP_W-1:0]  op_s;
  logic [RA_W-1:0]  rd_s;
  logic [RA_W-1:0]  rs1_s;
  logic [RA_W-1:0]  rs2_s;
  logic [IMM_W-1:0] imm_s;
  logic             reads_s;
  logic             writes_s;
  logic             legal_s;
  logic             busy_rs1_s;
  logic             busy_rs2_s;
  logic             busy_rd_s;
  logic             hazard_s;
  logic             ready_s;
  logic             accept_s;
  logic             inc_s;
  logic             dec_s;

  assign op_s  = bus.instr[OP_HI:OP_LO];
  assign rd_s  = bus.instr[RD_HI:RD_LO];
  assign rs1_s = bus.instr[RS1_HI:RS1_LO];
  assign rs2_s = bus.instr[RS2_HI:RS2_LO];
  assign imm_s = bus.instr[IMM_HI:IMM_LO];

  assign reads_s  = op_reads(op_s);
  assign writes_s = op_writes(op_s);
  assign legal_s  = op_legal(op_s);

  decode_issue_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (inc_s),
    .set_idx_i  (rd_s),
    .clr_en_i   (bus.wb_valid),
    .clr_idx_i  (bus.wb_ws),
    .rs1_i      (rs1_s),
    .rs2_i      (rs2_s),
    .rd_i       (rd_s),
    .busy_rs1_o (busy_rs1_s),
    .busy_rs2_o (busy_rs2_s),
    .busy_rd_o  (busy_rd_s)
  );

  // Illegal ops decode as neither reading nor writing, so they never stall.
  assign hazard_s = (reads_s && (busy_rs1_s || busy_rs2_s)) || (writes_s && busy_rd_s);
  assign accept_s = bus.instr_valid && ready_s;
  assign inc_s    = accept_s && writes_s;
  assign dec_s    = bus.wb_valid && (inflight_q != '0);

  // Run/halt state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accept readiness.
  always_comb begin
    state_d = state_q;
    ready_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        ready_s = !hazard_s && (inflight_q < MAX_CNT);
        if (bus.instr_valid && ready_s && (op_s == OP_HALT)) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        ready_s = 1'b0;
        state_d = ST_HALTED;
      end
      default: begin
        ready_s = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  // In-flight write count; a retire with nothing outstanding does not wrap.
  always_comb begin
    inflight_d = inflight_q;
    case ({inc_s, dec_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue registers: strobes pulse per accept, payload holds between accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rf_q       <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_ws_q    <= '0;
      ex_imm_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rf_q       <= accept_s && reads_s;
      ex_valid_q <= accept_s && (op_s != OP_HALT);
      if (accept_s) begin
        rs1_q    <= rs1_s;
        rs2_q    <= rs2_s;
        ex_op_q  <= op_s;
        ex_ws_q  <= rd_s;
        ex_imm_q <= {{(DW - IMM_W){1'b0}}, imm_s};
      end
      if (accept_s && !legal_s) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign bus.instr_ready = ready_s;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rf          = rf_q;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_ws       = ex_ws_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hazards, in-flight limit, same-edge
// set/clear, illegal/halt and reset mid-stall, with hand-computed values.
module tb_decode_issue;
  import decode_issue_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  decode_issue_if #(.DW(DEF_DW)) bus ();

  decode_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.wb_valid    = 1'b0;
    bus.wb_ws       = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_rf",       32'(bus.rf),          32'h0);
    chk("rst_ex_valid", 32'(bus.ex_valid),    32'h0);
    chk("rst_rs1",      32'(bus.rs1),         32'h0);
    chk("rst_ex_op",    32'(bus.ex_op),       32'h0);
    chk("rst_ex_imm",   32'(bus.ex_imm),      32'h0);
    chk("rst_halted",   32'(bus.halted),      32'h0);
    chk("rst_illegal",  32'(bus.illegal),     32'h0);
    chk("rst_ready",    32'(bus.instr_ready), 32'h1);
    chk("rst_sb",       32'(dut.u_sb.busy_q), 32'h0);
    chk("rst_inflight", 32'(dut.inflight_q),  32'h0);

    // ADD r3,r1,r2
    bus.instr = 16'h1650;
    bus.instr_valid = 1'b1;
    #1;
    chk("add_ready", 32'(bus.instr_ready), 32'h1);
    tick();
    bus.instr_valid = 1'b0;
    chk("add_rf",       32'(bus.rf),          32'h1);
    chk("add_rs1",      32'(bus.rs1),         32'h1);
    chk("add_rs2",      32'(bus.rs2),         32'h2);
    chk("add_ex_valid", 32'(bus.ex_valid),    32'h1);
    chk("add_ex_op",    32'(bus.ex_op),       32'h1);
    chk("add_ex_ws",    32'(bus.ex_ws),       32'h3);
    chk("add_ex_imm",   32'(bus.ex_imm),      32'h050);
    chk("add_sb",       32'(dut.u_sb.busy_q), 32'h08);
    chk("add_inflight", 32'(dut.inflight_q),  32'h1);

    // SUB r4,r3,r1 stalls on r3 until its writeback
    bus.instr = 16'h28C8;
    bus.instr_valid = 1'b1;
    #1;
    chk("sub_ready0", 32'(bus.instr_ready), 32'h0);
    tick();
    chk("sub_stall_rf",    32'(bus.rf),          32'h0);
    chk("sub_stall_valid", 32'(bus.ex_valid),    32'h0);
    chk("sub_hold_rs1",    32'(bus.rs1),         32'h1);
    chk("sub_hold_op",     32'(bus.ex_op),       32'h1);
    chk("sub_ready1",      32'(bus.instr_ready), 32'h0);
    tick();
    chk("sub_ready2", 32'(bus.instr_ready), 32'h0);
    bus.wb_valid = 1'b1;
    bus.wb_ws = 3'd3;
    #1;
    chk("sub_ready_wb", 32'(bus.instr_ready), 32'h0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("sub_not_yet",     32'(bus.ex_valid),    32'h0);
    chk("sub_ready_after", 32'(bus.instr_ready), 32'h1);
    chk("sub_sb_clr",      32'(dut.u_sb.busy_q), 32'h0);
    chk("sub_infl_clr",    32'(dut.inflight_q),  32'h0);
    tick();
    bus.instr_valid = 1'b0;
    chk("sub_ex_valid", 32'(bus.ex_valid),    32'h1);
    chk("sub_rf",       32'(bus.rf),          32'h1);
    chk("sub_ex_op",    32'(bus.ex_op),       32'h2);
    chk("sub_ex_ws",    32'(bus.ex_ws),       32'h4);
    chk("sub_rs1",      32'(bus.rs1),         32'h3);
    chk("sub_rs2",      32'(bus.rs2),         32'h1);
    chk("sub_ex_imm",   32'(bus.ex_imm),      32'h0C8);
    chk("sub_sb",       32'(dut.u_sb.busy_q), 32'h10);
    chk("sub_inflight", 32'(dut.inflight_q),  32'h1);
    bus.wb_valid = 1'b1;
    bus.wb_ws = 3'd4;
    tick();
    bus.wb_valid = 1'b0;
    chk("r4_ret_sb",   32'(dut.u_sb.busy_q), 32'h0);
    chk("r4_ret_infl", 32'(dut.inflight_q),  32'h0);

    // Four LDIs fill the in-flight window
    bus.instr_valid = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      bus.instr = {4'h5, 3'(r), 9'(r * 33)};
      tick();
    end
    bus.instr_valid = 1'b0;
    chk("ldi4_inflight", 32'(dut.inflight_q),  32'h4);
    chk("ldi4_sb",       32'(dut.u_sb.busy_q), 32'h1E);
    chk("ldi4_ex_ws",    32'(bus.ex_ws),       32'h4);
    chk("ldi4_ex_imm",   32'(bus.ex_imm),      32'h084);
    chk("ldi4_ex_op",    32'(bus.ex_op),       32'h5);
    chk("ldi4_rf",       32'(bus.rf),          32'h0);
    chk("ldi4_ex_valid", 32'(bus.ex_valid),    32'h1);
    bus.instr = 16'h5BFF;
    bus.instr_valid = 1'b1;
    #1;
    chk("ldi5_ready0", 32'(bus.instr_ready), 32'h0);
    tick();
    chk("ldi5_stall_valid", 32'(bus.ex_valid), 32'h0);
    chk("ldi5_hold_ws",     32'(bus.ex_ws),    32'h4);
    bus.wb_valid = 1'b1;
    bus.wb_ws = 3'd1;
    #1;
    chk("ldi5_ready_wb", 32'(bus.instr_ready), 32'h0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("ldi5_ready1",  32'(bus.instr_ready), 32'h1);
    chk("ldi5_infl3",   32'(dut.inflight_q),  32'h3);
    chk("ldi5_sb1c",    32'(dut.u_sb.busy_q), 32'h1C);
    chk("ldi5_novalid", 32'(bus.ex_valid),    32'h0);
    tick();
    bus.instr_valid = 1'b0;
    chk("ldi5_ex_valid", 32'(bus.ex_valid),    32'h1);
    chk("ldi5_ex_ws",    32'(bus.ex_ws),       32'h5);
    chk("ldi5_ex_imm",   32'(bus.ex_imm),      32'h1FF);
    chk("ldi5_infl4",    32'(dut.inflight_q),  32'h4);
    chk("ldi5_sb",       32'(dut.u_sb.busy_q), 32'h3C);

    // Retire r2, then LDI r2 and wb r2 on the same edge
    bus.wb_valid = 1'b1;
    bus.wb_ws = 3'd2;
    tick();
    bus.wb_valid = 1'b0;
    chk("r2_ret_infl", 32'(dut.inflight_q),  32'h3);
    chk("r2_ret_sb",   32'(dut.u_sb.busy_q), 32'h38);
    bus.instr = 16'h5433;
    bus.instr_valid = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_ws = 3'd2;
    #1;
    chk("same_ready", 32'(bus.instr_ready), 32'h1);
    tick();
    bus.instr_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("same_sb",       32'(dut.u_sb.busy_q), 32'h3C);
    chk("same_infl",     32'(dut.inflight_q),  32'h3);
    chk("same_ex_valid", 32'(bus.ex_valid),    32'h1);
    chk("same_ex_ws",    32'(bus.ex_ws),       32'h2);
    chk("same_ex_imm",   32'(bus.ex_imm),      32'h033);

    // Drain four busy bits with only three counted: count must stop at 0
    bus.wb_valid = 1'b1;
    for (int w = 2; w <= 5; w++) begin
      bus.wb_ws = 3'(w);
      tick();
    end
    bus.wb_valid = 1'b0;
    chk("drain_infl", 32'(dut.inflight_q),  32'h0);
    chk("drain_sb",   32'(dut.u_sb.busy_q), 32'h0);

    // Reset while stalled on a hazard
    bus.instr = 16'h5CAA;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr = 16'h13B0;
    #1;
    chk("haz_ready0", 32'(bus.instr_ready), 32'h0);
    tick();
    chk("haz_ready1", 32'(bus.instr_ready), 32'h0);
    chk("haz_valid",  32'(bus.ex_valid),    32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    chk("mrst_sb",       32'(dut.u_sb.busy_q), 32'h0);
    chk("mrst_infl",     32'(dut.inflight_q),  32'h0);
    chk("mrst_ready",    32'(bus.instr_ready), 32'h1);
    chk("mrst_rf",       32'(bus.rf),          32'h0);
    chk("mrst_ex_valid", 32'(bus.ex_valid),    32'h0);
    chk("mrst_ex_op",    32'(bus.ex_op),       32'h0);
    chk("mrst_ex_ws",    32'(bus.ex_ws),       32'h0);
    chk("mrst_ex_imm",   32'(bus.ex_imm),      32'h0);
    chk("mrst_rs1",      32'(bus.rs1),         32'h0);
    chk("mrst_rs2",      32'(bus.rs2),         32'h0);

    // Illegal opcode 9
    bus.instr = 16'h9ABC;
    bus.instr_valid = 1'b1;
    #1;
    chk("ill_ready", 32'(bus.instr_ready), 32'h1);
    tick();
    bus.instr_valid = 1'b0;
    chk("ill_flag",     32'(bus.illegal),     32'h1);
    chk("ill_ex_valid", 32'(bus.ex_valid),    32'h1);
    chk("ill_ex_op",    32'(bus.ex_op),       32'h9);
    chk("ill_ex_ws",    32'(bus.ex_ws),       32'h5);
    chk("ill_ex_imm",   32'(bus.ex_imm),      32'h0BC);
    chk("ill_rf",       32'(bus.rf),          32'h0);
    chk("ill_sb",       32'(dut.u_sb.busy_q), 32'h0);
    chk("ill_infl",     32'(dut.inflight_q),  32'h0);
    tick();
    tick();
    chk("ill_sticky", 32'(bus.illegal), 32'h1);

    // HALT, then nothing is accepted
    bus.instr = 16'hF000;
    bus.instr_valid = 1'b1;
    #1;
    chk("halt_ready", 32'(bus.instr_ready), 32'h1);
    tick();
    bus.instr = 16'h0000;
    chk("halt_flag",  32'(bus.halted),      32'h1);
    chk("halt_rdy0",  32'(bus.instr_ready), 32'h0);
    chk("halt_valid", 32'(bus.ex_valid),    32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_hold_ready", 32'(bus.instr_ready), 32'h0);
      chk("halt_hold_flag",  32'(bus.halted),      32'h1);
      chk("halt_hold_valid", 32'(bus.ex_valid),    32'h0);
      chk("halt_hold_ill",   32'(bus.illegal),     32'h1);
    end

    // Only reset leaves HALTED and clears illegal
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    chk("frst_halted",  32'(bus.halted),      32'h0);
    chk("frst_illegal", 32'(bus.illegal),     32'h0);
    chk("frst_ready",   32'(bus.instr_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
